// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 message-schedule expander.
// Sigma rotation/shift amounts, word type and the schedule FSM states.
package sha256_pkg;

    localparam int WORD_W      = 32;
    localparam int BLOCK_WORDS = 16;

    localparam int S0_R1 = 7;
    localparam int S0_R2 = 18;
    localparam int S0_S  = 3;

    localparam int S1_R1 = 17;
    localparam int S1_R2 = 19;
    localparam int S1_S  = 10;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic {
        ST_LOAD   = 1'b0,
        ST_EXPAND = 1'b1
    } state_t;

endpackage

// File: rtl/sha256_sigma.sv
// SHA-256 small sigma: two rotates and one logical shift, XORed.
// Pure combinational; instantiated once for sigma0 and once for sigma1.
module sha256_sigma
    import sha256_pkg::*;
#(
    parameter int R1 = 7,
    parameter int R2 = 18,
    parameter int S  = 3
) (
    input  word_t x,
    output word_t y
);

    word_t rot1;
    word_t rot2;
    word_t shr;

    assign rot1 = (x >> R1) | (x << (WORD_W - R1));
    assign rot2 = (x >> R2) | (x << (WORD_W - R2));
    assign shr  = x >> S;

    assign y = rot1 ^ rot2 ^ shr;

endmodule

// File: rtl/sha256_msg_schedule.sv
// Streaming SHA-256 message-schedule expander: loads 16 words, then
// emits W[0..ROUNDS-1] from a 16-word sliding window, one per handshake.
module sha256_msg_schedule
    import sha256_pkg::*;
#(
    parameter int ROUNDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_word,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic        out_last,
    output logic        busy
);

    localparam logic [5:0] CNT_LOAD_END = 6'(BLOCK_WORDS - 1);
    localparam logic [5:0] CNT_LAST     = 6'(ROUNDS - 1);

    word_t      w [BLOCK_WORDS];
    logic [5:0] cnt;
    state_t     state;
    state_t     state_nx;

    logic  in_fire;
    logic  out_fire;
    word_t sig0;
    word_t sig1;
    word_t w_new;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    sha256_sigma #(
        .R1 (S0_R1),
        .R2 (S0_R2),
        .S  (S0_S)
    ) u_sigma0 (
        .x (w[1]),
        .y (sig0)
    );

    sha256_sigma #(
        .R1 (S1_R1),
        .R2 (S1_R2),
        .S  (S1_S)
    ) u_sigma1 (
        .x (w[14]),
        .y (sig1)
    );

    // W[t+16] from the window while W[t] sits at the head; wraps mod 2^32
    assign w_new = sig1 + w[9] + sig0 + w[0];

    // Head of the window is a register, so out_word has no comb input path
    assign out_word = w[0];

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_LOAD;
        end else begin
            state <= state_nx;
        end
    end

    // Next state: leave LOAD on 16th accept, leave EXPAND on last handshake
    always_comb begin
        state_nx = state;
        unique case (state)
            ST_LOAD: begin
                if (in_fire && cnt == CNT_LOAD_END) begin
                    state_nx = ST_EXPAND;
                end
            end
            ST_EXPAND: begin
                if (out_fire && out_last) begin
                    state_nx = ST_LOAD;
                end
            end
            default: state_nx = ST_LOAD;
        endcase
    end

    // Handshake and status outputs decoded from state and counter
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        busy      = 1'b1;
        unique case (state)
            ST_LOAD: begin
                in_ready = 1'b1;
                busy     = (cnt != 6'd0);
            end
            ST_EXPAND: begin
                out_valid = 1'b1;
                out_last  = (cnt == CNT_LAST);
            end
            default: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
        endcase
    end

    // Window shift and counter: loads input words or feeds back W[t+16]
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BLOCK_WORDS; i++) begin
                w[i] <= '0;
            end
            cnt <= '0;
        end else if (in_fire) begin
            for (int i = 0; i < BLOCK_WORDS - 1; i++) begin
                w[i] <= w[i+1];
            end
            w[BLOCK_WORDS-1] <= in_word;
            cnt <= (cnt == CNT_LOAD_END) ? 6'd0 : cnt + 6'd1;
        end else if (out_fire) begin
            for (int i = 0; i < BLOCK_WORDS - 1; i++) begin
                w[i] <= w[i+1];
            end
            w[BLOCK_WORDS-1] <= w_new;
            cnt <= out_last ? 6'd0 : cnt + 6'd1;
        end
    end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Scoreboard bench for the SHA-256 message-schedule expander.
// Expected schedules come from a plain-arithmetic SHA-256 model.
module tb_sha256_msg_schedule;

    localparam int R = 64;

    typedef logic [31:0] wd_t;
    typedef struct {
        wd_t  w;
        logic last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic in_ready;
    logic [31:0] in_word = '0;
    logic out_valid;
    logic out_ready = 1'b1;
    logic [31:0] out_word;
    logic out_last;
    logic busy;

    sha256_msg_schedule #(.ROUNDS(R)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_word   (in_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];
    wd_t  obs[$];
    int   acc_cnt = 0;
    int   last_cnt = 0;
    logic last_seen = 1'b0;
    logic prev_stall = 1'b0;
    wd_t  prev_word = '0;
    logic rmode = 1'b0;
    logic pulses = 1'b0;
    wd_t  ref_w [R];
    wd_t  blk [16];

    task automatic chk(input string nm, input wd_t act, input wd_t expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic wd_t rotr(input wd_t x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Reference schedule straight from the SHA-256 definition
    task automatic model(input wd_t b [16]);
        wd_t s0;
        wd_t s1;
        for (int t = 0; t < R; t++) begin
            if (t < 16) begin
                ref_w[t] = b[t];
            end else begin
                s0 = rotr(ref_w[t-15], 7) ^ rotr(ref_w[t-15], 18)
                   ^ (ref_w[t-15] >> 3);
                s1 = rotr(ref_w[t-2], 17) ^ rotr(ref_w[t-2], 19)
                   ^ (ref_w[t-2] >> 10);
                ref_w[t] = s1 + ref_w[t-7] + s0 + ref_w[t-16];
            end
        end
    endtask

    // Downstream ready: constant or random, changed just after each edge
    always @(posedge clk) begin
        #1;
        out_ready = rmode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: pops the scoreboard on every output handshake
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_stall = 1'b0;
            last_seen  = 1'b0;
        end else begin
            if (prev_stall && out_valid) begin
                chk("stall_hold", out_word, prev_word);
            end
            if (last_seen) begin
                chk("in_ready_after_last", 32'(in_ready), 32'd1);
                chk("out_valid_after_last", 32'(out_valid), 32'd0);
                last_seen = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 32'(out_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("word[%0d]", obs.size()), out_word, e.w);
                    chk($sformatf("last[%0d]", obs.size()),
                        32'(out_last), 32'(e.last));
                    obs.push_back(out_word);
                    acc_cnt++;
                    if (out_last) begin
                        last_cnt++;
                        last_seen = 1'b1;
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_word  = out_word;
        end
    end

    task automatic chk_reset(input string tag);
        chk({tag, "_in_ready"},  32'(in_ready),  32'd1);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_word"},  out_word,       32'd0);
        chk({tag, "_out_last"},  32'(out_last),  32'd0);
        chk({tag, "_busy"},      32'(busy),      32'd0);
    endtask

    // Feed n words, one every (gap+1) cycles
    task automatic load_words(input int n, input int gap);
        int k;
        k = 0;
        while (!in_ready && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_word  = blk[i];
            if (i == 15) chk("no_early_valid", 32'(out_valid), 32'd0);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            if (i == 15) begin
                @(negedge clk);
                chk("first_valid", 32'(out_valid), 32'd1);
                chk("ready_low_expand", 32'(in_ready), 32'd0);
            end else begin
                repeat (gap) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
    endtask

    task automatic push_expect();
        model(blk);
        for (int t = 0; t < R; t++) begin
            exp_q.push_back('{ref_w[t], (t == R - 1)});
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 2000) begin
            @(posedge clk);
            #1;
            if (pulses && exp_q.size() > 1) begin
                in_valid = 1'($urandom_range(0, 1));
                in_word  = $urandom;
            end else begin
                in_valid = 1'b0;
            end
            n++;
        end
        in_valid = 1'b0;
        if (exp_q.size() > 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic run_block(input int gap);
        obs.delete();
        last_cnt = 0;
        acc_cnt  = 0;
        push_expect();
        load_words(16, gap);
        drain();
    endtask

    task automatic set_abc();
        for (int i = 0; i < 16; i++) blk[i] = '0;
        blk[0]  = 32'h61626380;
        blk[15] = 32'h00000018;
    endtask

    task automatic set_rand();
        for (int i = 0; i < 16; i++) blk[i] = $urandom;
    endtask

    task automatic check_abc(input string tag);
        chk({tag, "_count"}, 32'(obs.size()), 32'd64);
        chk({tag, "_lastcnt"}, 32'(last_cnt), 32'd1);
        if (obs.size() == 64) begin
            chk({tag, "_W0"},  obs[0],  32'h61626380);
            chk({tag, "_W15"}, obs[15], 32'h00000018);
            chk({tag, "_W16"}, obs[16], 32'h61626380);
            chk({tag, "_W17"}, obs[17], 32'h000F0000);
            chk({tag, "_W63"}, obs[63], 32'h12B1EDEB);
        end
    endtask

    task automatic pulse_reset(input string tag);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_reset(tag);
        exp_q.delete();
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        int k;
        #2;
        chk_reset("por");
        @(posedge clk);
        #2;
        rst = 1'b0;

        set_abc();
        run_block(0);
        check_abc("abc");

        rmode = 1'b1;
        run_block(0);
        check_abc("abc_bp");
        rmode = 1'b0;

        pulses = 1'b1;
        run_block(2);
        check_abc("abc_gap");
        pulses = 1'b0;

        for (int i = 0; i < 16; i++) blk[i] = 32'hFFFFFFFF;
        rmode = 1'b1;
        run_block(0);
        chk("ones_lastcnt", 32'(last_cnt), 32'd1);
        rmode = 1'b0;

        set_rand();
        load_words(8, 0);
        @(negedge clk);
        chk("busy_partial", 32'(busy), 32'd1);
        pulse_reset("rst_load");

        set_rand();
        obs.delete();
        acc_cnt = 0;
        push_expect();
        load_words(16, 0);
        k = 0;
        while (acc_cnt < 30 && k < 200) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("reach_t30", 32'(acc_cnt), 32'd30);
        pulse_reset("rst_expand");

        set_abc();
        run_block(0);
        check_abc("abc_after_rst");

        for (int b = 0; b < 3; b++) begin
            set_rand();
            rmode = 1'(b % 2);
            pulses = 1'(b % 2);
            run_block(0);
            chk("b2b_lastcnt", 32'(last_cnt), 32'd1);
        end
        rmode = 1'b0;
        pulses = 1'b0;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sha256_msg_schedule.md
# sha256_msg_schedule

Streaming SHA-256 message-schedule expander: accepts the 16 32-bit words of one message block and emits the 64 schedule words W[0..63] in order. It is the consumer side of the fixed-rotation primitives (ROTR7 etc.): σ0/σ1 are built from those rotations and applied sequentially over a 16-word sliding window. It sits between the block loader and the compression-round datapath of the miner core.

## Interface
- `ROUNDS`, 64: number of schedule words emitted per block (must be ≥16).
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  `in_word` valid.
- `in_ready`  out  1  block accepts an input word (LOAD state).
- `in_word`  in  32  message word, W[0] first, big-endian word order.
- `out_valid`  out  1  `out_word` valid (EXPAND state).
- `out_ready`  in  1  downstream accepts `out_word`.
- `out_word`  out  32  schedule word W[t].
- `out_last`  out  1  high with W[ROUNDS-1].
- `busy`  out  1  high whenever not in LOAD, or LOAD with ≥1 word captured.

## Operation
- State: 16×32 window `w[0..15]`, 6-bit counter `cnt`, FSM {LOAD, EXPAND}.
- LOAD: `in_ready`=1, `out_valid`=0. Each `in_valid&&in_ready`: `w[15]<=in_word`, `w[i]<=w[i+1]`, `cnt++`. On the 16th accept: `cnt<=0`, → EXPAND.
- EXPAND: `in_ready`=0, `out_valid`=1, `out_word`=`w[0]`, `out_last`=(`cnt`==ROUNDS-1).
- On `out_valid&&out_ready`: `w[i]<=w[i+1]`, `w[15]<=σ1(w[14])+w[9]+σ0(w[1])+w[0]` (mod 2^32, carries discarded), `cnt++`. This computes W[t+16] while emitting W[t].
- After the handshake with `out_last`=1: `cnt<=0`, → LOAD. Window contents don't care.
- σ0(x)=ROTR7(x)^ROTR18(x)^SHR3(x); σ1(x)=ROTR17(x)^ROTR19(x)^SHR10(x). ROTR is a pure rotate (bit i of result = bit (i+n) mod 32 of x); SHR zero-fills.
- Backpressure: `out_ready`=0 holds `w`, `cnt`, and outputs stable; `out_word` must not change while `out_valid`=1 and unaccepted.
- `in_valid` during EXPAND is ignored (not captured).

## Timing
- Reset (async assert, sync-safe deassert): state LOAD, `cnt`=0, `w`=0; outputs `in_ready`=1, `out_valid`=0, `out_word`=0, `out_last`=0, `busy`=0.
- Reset mid-LOAD or mid-EXPAND aborts the block; the next accepted word is W[0] of a new block.
- Load: 16 cycles minimum (one word per cycle at `in_valid`=1).
- First `out_valid` the cycle after the 16th input handshake. Throughput 1 word/cycle with `out_ready`=1; ROUNDS cycles to drain.
- `in_ready` rises the cycle after the `out_last` handshake; no overlap between blocks (minimum 16+ROUNDS cycles/block).
- Critical path: σ0/σ1 in parallel, then 4-input 32-bit add; `out_word` is a register output (no combinational in→out path).

## Structure
- `sha256_pkg`: `WORD_W`=32, `BLOCK_WORDS`=16, rotation/shift constants (7,18,3; 17,19,10), `word_t` typedef, FSM state enum.
- Sub-module `sha256_sigma` (combinational, parameters R1, R2, S): `y = ROTR(x,R1)^ROTR(x,R2)^SHR(x,S)`; instantiated twice (σ0, σ1).
- Adder, window, FSM in the top.

## Test plan
- "abc" block (W0=0x61626380, W1..W14=0, W15=0x00000018), `out_ready`=1 → W0..W15 echoed, W16=0x61626380, W17=0x000F0000, W63=0x12B1EDEB with `out_last`=1 exactly once.
- Same block with `out_ready` toggled pseudo-randomly → identical word sequence; `out_word` stable during every stall cycle.
- `in_valid` gapped (one word every 3 cycles) → `out_valid` first asserted 1 cycle after 16th accept; `in_valid` pulses during EXPAND not captured.
- All-ones block (W0..W15=0xFFFFFFFF) → outputs match software SHA-256 model for all 64 words (exercises carry wrap).
- Assert `rst` after 8 loaded words and again at t=30 of EXPAND → outputs return to reset values immediately; following "abc" block produces correct full schedule.
- Two back-to-back blocks → `in_ready` reasserts one cycle after first `out_last` handshake; second block's schedule independent of first.
